// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed FIFO slice.
// Holds the read-during-write mode the FIFO relies on for its empty-queue bypass.
package sram_fifo_pkg;

  localparam string SRAM_RDW_MODE = "NEW_DATA";

endpackage

// File: rtl/sram_1r1w.sv
// Single-port-read, single-port-write synchronous SRAM, one cycle read latency.
// READ_DURING_WRITE="NEW_DATA" forwards write_data when read and write addresses match.
module sram_1r1w #(
  parameter int    DATA_WIDTH        = 64,
  parameter int    SIZE              = 64,
  parameter string READ_DURING_WRITE = "NEW_DATA",
  parameter int    ADDR_WIDTH        = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  generate
    if (READ_DURING_WRITE == "NEW_DATA") begin : g_new_data
      always_ff @(posedge clk) begin
        if (read_en)
          read_data <= (write_en && (write_addr == read_addr)) ? write_data : mem[read_addr];
      end
    end else begin : g_old_data
      always_ff @(posedge clk) begin
        if (read_en) read_data <= mem[read_addr];
      end
    end
  endgenerate

endmodule

// File: rtl/sram_fifo.sv
// Show-ahead FIFO on one sram_1r1w; head entry is on value_o with no dequeue latency.
// Optional SRAM_FIFO_CHECK_EN adds simulation-only overflow/underflow/count assertions.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH                  = 64,
  parameter int SIZE                   = 64,
  parameter int ALMOST_FULL_THRESHOLD  = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter int ADDR_WIDTH             = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_en,
  input  logic             enqueue_en,
  input  logic [WIDTH-1:0] value_i,
  input  logic             dequeue_en,
  output logic [WIDTH-1:0] value_o,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  do_enq;
  logic                  do_deq;

  // A dequeue frees a slot, so a full FIFO still accepts a simultaneous enqueue.
  assign do_enq = enqueue_en & (~full | dequeue_en) & ~flush_en;
  assign do_deq = dequeue_en & ~empty & ~flush_en;

  // Always read the entry that will be head after this edge; the SRAM bypass
  // covers the case where that entry is being written this same cycle.
  assign read_addr = flush_en ? '0 : (do_deq ? head + 1'b1 : head);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_en) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (do_deq) head <= head + 1'b1;
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (do_deq && !do_enq) count <= count - 1'b1;
    end
  end

  assign full         = (count == CW'(SIZE));
  assign almost_full  = (count >= CW'(ALMOST_FULL_THRESHOLD));
  assign empty        = (count == '0);
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_THRESHOLD));

  sram_1r1w #(
    .DATA_WIDTH        (WIDTH),
    .SIZE              (SIZE),
    .READ_DURING_WRITE (SRAM_RDW_MODE)
  ) u_sram (
    .clk        (clk),
    .write_en   (do_enq),
    .write_addr (tail),
    .write_data (value_i),
    .read_en    (1'b1),
    .read_addr  (read_addr),
    .read_data  (value_o)
  );

`ifdef SRAM_FIFO_CHECK_EN
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(enqueue_en && full && !dequeue_en))
    else $error("sram_fifo overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(dequeue_en && empty))
    else $error("sram_fifo underflow");

  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    count <= CW'(SIZE))
    else $error("sram_fifo count exceeds SIZE");
`endif

endmodule
